sw_input_conditioner: RTL and testbench

- Upstream input stage for the 3-bit switch-driven accumulator/adder datapath that drives the hex7seg display.
- Synchronises and debounces the 3 raw slide switches plus one push-button key.
- Each clean button press delivers one 3-bit operand to the downstream accumulator over a valid/ready handshake.
- Downstream therefore adds once per press, not on every clock.

---
 rtl/sw_input_conditioner_if.sv | 9 +
 rtl/sw_input_conditioner.sv | 130 +++++++++++++
 tb/tb_sw_input_conditioner.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sw_input_conditioner_if.sv
// Operand handshake between the input conditioner and the downstream accumulator.
interface sw_input_conditioner_if;
    logic [2:0] op_data;
    logic       op_valid;
    logic       op_ready;

    modport master (output op_data, output op_valid, input op_ready);
    modport slave  (input op_data, input op_valid, output op_ready);
endinterface

// File: rtl/sw_input_conditioner.sv
// Synchronise + debounce 3 slide switches and a key; one operand per clean press.
// Optional auto-repeat while the key is held: define AUTO_REPEAT_EN.
module sw_input_conditioner #(
    parameter int unsigned DB_CYCLES     = 4,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned REPEAT_CYCLES = 8
) (
    input  logic                          Clock,
    input  logic                          Resetn,
    input  logic [2:0]                    sw,
    input  logic                          key,
    sw_input_conditioner_if.master        op,
    output logic [2:0]                    sw_stable,
    output logic                          overrun
);

    if (DB_CYCLES < 2 || (CNT_W < 63 && (64'd1 << CNT_W) <= 64'(DB_CYCLES))) begin : g_bad_db
        $error("sw_input_conditioner: DB_CYCLES must be >= 2 and < 2**CNT_W");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_rep
        $error("sw_input_conditioner: REPEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // bit 3 is the key, bits 2:0 the switches
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       stable;
    logic [CNT_W-1:0] cnt [4];
    logic             kd;

    state_t state;
    state_t state_nx;
    logic   load;
    logic   rep_hit;

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {key, sw};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            stable <= '0;
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign kd        = stable[3];
    assign sw_stable = stable[2:0];

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] rcnt;

    assign rep_hit = (state == HELD) && kd && (rcnt == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            rcnt <= '0;
        end else if (state == HELD && kd) begin
            rcnt <= rep_hit ? '0 : rcnt + RW'(1);
        end else begin
            rcnt <= '0;
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Resetn) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE:  if (kd) state_nx = PRESS;
            PRESS: begin
                load     = 1'b1;
                state_nx = HELD;
            end
            HELD: begin
                if (!kd) state_nx = IDLE;
                else     load     = rep_hit;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A load in the same cycle as an accept replaces the operand instead of clearing valid.
    always_ff @(posedge Clock) begin
        if (Resetn) begin
            op.op_valid <= 1'b0;
            op.op_data  <= '0;
            overrun     <= 1'b0;
        end else if (load) begin
            if (!op.op_valid || op.op_ready) begin
                op.op_valid <= 1'b1;
                op.op_data  <= sw_stable;
            end else begin
                overrun <= 1'b1;
            end
        end else if (op.op_valid && op.op_ready) begin
            op.op_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner with a cycle-level reference model.
module tb_sw_input_conditioner;
    localparam int DB  = 4;
    localparam int REP = 8;
`ifdef AUTO_REPEAT_EN
    localparam int PER_PRESS = 2;  // 10-cycle hold: initial operand plus one repeat
    localparam int LONG_HOLD = 4;
`else
    localparam int PER_PRESS = 1;
    localparam int LONG_HOLD = 1;
`endif

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b1;
    logic [2:0] sw     = '0;
    logic       key    = 1'b0;
    logic [2:0] sw_stable;
    logic       overrun;

    sw_input_conditioner_if ifc();

    sw_input_conditioner #(
        .DB_CYCLES    (DB),
        .CNT_W        (16),
        .REPEAT_CYCLES(REP)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .sw       (sw),
        .key      (key),
        .op       (ifc),
        .sw_stable(sw_stable),
        .overrun  (overrun)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int passed = 0;
    int n_valid = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: raw sample history, debounced levels, press events, handshake.
    int         k        = 100;
    int         last_rst = 0;
    int         rise     = -1;
    logic [3:0] hist [64];
    logic [3:0] m_stab   = '0;
    logic       m_valid  = 1'b0;
    logic [2:0] m_data   = '0;
    logic       m_ovr    = 1'b0;
    bit         started  = 0;

    initial for (int i = 0; i < 64; i++) hist[i] = '0;

    always @(posedge Clock) begin
        logic       load;
        logic       acc;
        logic       flip;
        logic [3:0] nxt;
        k++;
        started = 1;
        if (Resetn) begin
            m_stab   = '0;
            m_valid  = 1'b0;
            m_data   = '0;
            m_ovr    = 1'b0;
            rise     = -1;
            last_rst = k;
            hist[k % 64]       = '0;
            hist[(k - 1) % 64] = '0;
        end else begin
            hist[k % 64] = {key, sw};
            load = 1'b0;
            if (rise >= 0 && m_stab[3]) begin
                if (k == rise + 2) load = 1'b1;
`ifdef AUTO_REPEAT_EN
                else if (k > rise + 2 && (k - rise - 2) % REP == 0) load = 1'b1;
`endif
            end
            acc = m_valid && ifc.op_ready;
            if (load) begin
                if (!m_valid || acc) begin
                    m_valid = 1'b1;
                    m_data  = m_stab[2:0];
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (acc) begin
                m_valid = 1'b0;
            end
            // a level flips once the last DB synchronised samples all disagree with it
            nxt = m_stab;
            if (k - DB - 1 >= last_rst - 1) begin
                for (int b = 0; b < 4; b++) begin
                    flip = 1'b1;
                    for (int j = 2; j <= DB + 1; j++)
                        if (hist[(k - j) % 64][b] == m_stab[b]) flip = 1'b0;
                    if (flip) nxt[b] = ~m_stab[b];
                end
            end
            if (!m_stab[3] && nxt[3]) rise = k;
            else if (m_stab[3] && !nxt[3]) rise = -1;
            m_stab = nxt;
        end
    end

    always @(negedge Clock) begin
        if (started) begin
            chk("op_valid", {7'd0, ifc.op_valid}, {7'd0, m_valid});
            chk("op_data", {5'd0, ifc.op_data}, {5'd0, m_data});
            chk("sw_stable", {5'd0, sw_stable}, {5'd0, m_stab[2:0]});
            chk("overrun", {7'd0, overrun}, {7'd0, m_ovr});
            if (ifc.op_valid) n_valid++;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        int n0;
        ifc.op_ready = 1'b0;

        // 1: reset, then switch latency
        tick(3);
        chk("rst_valid", {7'd0, ifc.op_valid}, 8'd0);
        chk("rst_data", {5'd0, ifc.op_data}, 8'd0);
        chk("rst_sw_stable", {5'd0, sw_stable}, 8'd0);
        chk("rst_overrun", {7'd0, overrun}, 8'd0);
        Resetn = 1'b0;
        tick(2);
        sw = 3'b101;
        tick(5);
        chk("t1_before_latency", {5'd0, sw_stable}, 8'h00);
        tick(1);
        chk("t1_at_latency", {5'd0, sw_stable}, 8'h05);
        chk("t1_model_pin", {5'd0, m_stab[2:0]}, 8'h05);

        // 2: key glitch shorter than the debounce window
        key = 1'b1;
        tick(2);
        key = 1'b0;
        tick(10);
        chk("t2_no_press", {7'd0, ifc.op_valid}, 8'd0);
        chk("t2_sw_kept", {5'd0, sw_stable}, 8'h05);
        chk("t2_model_kd", {7'd0, m_stab[3]}, 8'd0);

        // 3: clean presses with downstream ready
        sw = 3'b011;
        tick(8);
        ifc.op_ready = 1'b1;
        n0 = n_valid;
        key = 1'b1;
        tick(10);
        key = 1'b0;
        tick(10);
        chk("t3_one_operand", 8'(n_valid - n0), 8'(PER_PRESS));
        chk("t3_data", {5'd0, ifc.op_data}, 8'h03);
        key = 1'b1;
        tick(10);
        key = 1'b0;
        tick(10);
        chk("t3_second_operand", 8'(n_valid - n0), 8'(2 * PER_PRESS));

        // 4: stalled downstream, second press dropped
        ifc.op_ready = 1'b0;
        sw = 3'b010;
        tick(8);
        key = 1'b1;
        tick(10);
        key = 1'b0;
        tick(10);
        sw = 3'b111;
        tick(8);
        key = 1'b1;
        tick(10);
        key = 1'b0;
        tick(10);
        chk("t4_valid_held", {7'd0, ifc.op_valid}, 8'd1);
        chk("t4_data_kept", {5'd0, ifc.op_data}, 8'h02);
        chk("t4_overrun", {7'd0, overrun}, 8'd1);
        ifc.op_ready = 1'b1;
        tick(1);
        chk("t4_accepted", {7'd0, ifc.op_valid}, 8'd0);

        // 5: reset while an operand is pending and the key is held
        ifc.op_ready = 1'b0;
        sw = 3'b100;
        tick(8);
        key = 1'b1;
        tick(8);
        chk("t5_pending", {7'd0, ifc.op_valid}, 8'd1);
        Resetn = 1'b1;
        tick(1);
        Resetn = 1'b0;
        chk("t5_rst_valid", {7'd0, ifc.op_valid}, 8'd0);
        chk("t5_rst_overrun", {7'd0, overrun}, 8'd0);
        chk("t5_rst_sw", {5'd0, sw_stable}, 8'd0);
        for (int i = 0; i < 20 && !ifc.op_valid; i++) tick(1);
        chk("t5_requalified", {7'd0, ifc.op_valid}, 8'd1);
        chk("t5_data", {5'd0, ifc.op_data}, 8'h04);
        ifc.op_ready = 1'b1;
        key = 1'b0;
        tick(12);

        // 6: long hold
        sw = 3'b110;
        tick(8);
        n0 = n_valid;
        key = 1'b1;
        tick(30);
        key = 1'b0;
        tick(12);
        chk("t6_long_hold", 8'(n_valid - n0), 8'(LONG_HOLD));
        chk("t6_data", {5'd0, ifc.op_data}, 8'h06);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
